multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 58 +++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_control.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
//   - state_e  : FSM state encoding (also driven out on the debug state port)
//   - OP_*     : opcode field values (instruction[31:26])
//   - FN_*     : R-type funct field values (instruction[5:0])
//   - ALU_*    : alu_ctrl operation codes
//   - PC_SRC_* : pc_src mux selects
//   - ALUB_*   : alu_src_b mux selects
//   - is_mem_op: true for the load/store opcodes that share the address phase
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUB_REG     = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational R-type funct to alu_ctrl translation.
// Ports:
//   funct_i    in  6  funct field of the current instruction
//   alu_ctrl_o out 3  ALU operation code (ADD when funct is unknown)
//   valid_o    out 1  1 when funct is one of the supported operations
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       valid_o
);

    // Map funct to ALU op; unknown codes fall back to ADD and drop valid
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        case (funct_i)
            FN_ADD: begin
                alu_ctrl_o = ALU_ADD;
            end
            FN_SUB: begin
                alu_ctrl_o = ALU_SUB;
            end
            FN_AND: begin
                alu_ctrl_o = ALU_AND;
            end
            FN_OR: begin
                alu_ctrl_o = ALU_OR;
            end
            FN_SLT: begin
                alu_ctrl_o = ALU_SLT;
            end
            default: begin
                alu_ctrl_o = ALU_ADD;
                valid_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style sequencer for a multicycle MIPS datapath
// (lw, sw, R-type add/sub/and/or/slt, beq, addi, optional j).
// Build option: define MC_JUMP_EN to make opcode 000010 execute through the
// JUMP state; without it that opcode is reported on illegal_op from DECODE.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   opcode, funct      instruction fields from the instruction register
//   zero               ALU equal flag (qualifies pc_en in BRANCH)
//   mem_ready          memory access complete (ends FETCH/MEMRD/MEMWR waits)
//   pc_en, pc_src      PC load strobe and source select
//   iord               memory address select (0 PC, 1 ALU-out)
//   mem_read/mem_write memory requests
//   ir_write           instruction register load
//   reg_dst, mem_to_reg, reg_write  register file write controls
//   alu_src_a/_b, alu_ctrl          ALU operand selects and operation
//   state              current state for debug
//   instr_done         pulse on the last cycle of each instruction
//   illegal_op         pulse when an unsupported opcode or funct is decoded
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e     state_q;
    state_e     state_d;

    logic [2:0] dec_alu_ctrl_s;
    logic       dec_valid_s;

    logic       pc_en_s;
    logic [1:0] pc_src_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_ctrl_s;
    logic       instr_done_s;
    logic       illegal_op_s;

    alu_decoder u_alu_decoder (
        .funct_i    (funct),
        .alu_ctrl_o (dec_alu_ctrl_s),
        .valid_o    (dec_valid_s)
    );

    // State register; reset returns the sequencer to FETCH from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from the current state
    always_comb begin
        state_d      = state_q;
        pc_en_s      = 1'b0;
        pc_src_s     = PC_SRC_ALU;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = ALUB_REG;
        alu_ctrl_s   = ALU_ADD;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR load
                mem_read_s  = 1'b1;
                alu_src_b_s = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_en_s    = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target precomputed here for use in BRANCH
                alu_src_b_s = ALUB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: begin
                        state_d = S_MEMADR;
                    end
                    OP_RTYPE: begin
                        state_d = S_EXEC;
                    end
                    OP_BEQ: begin
                        state_d = S_BRANCH;
                    end
                    OP_ADDI: begin
                        state_d = S_ADDIEX;
                    end
`ifdef MC_JUMP_EN
                    OP_J: begin
                        state_d = S_JUMP;
                    end
`else
                    OP_J: begin
                        state_d      = S_FETCH;
                        illegal_op_s = 1'b1;
                    end
`endif
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = ALUB_IMM;
                if (!is_mem_op(opcode)) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                // The store is held on the bus until memory accepts it
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
                if (mem_ready) begin
                    instr_done_s = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    state_d      = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = dec_alu_ctrl_s;
                if (dec_valid_s) begin
                    state_d = S_ALUWB;
                end else begin
                    // Unknown funct: abandon the instruction before any write
                    illegal_op_s = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                // Compare via subtraction; the taken target sits in ALU-out
                alu_src_a_s  = 1'b1;
                alu_ctrl_s   = ALU_SUB;
                pc_src_s     = PC_SRC_ALUOUT;
                pc_en_s      = zero;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = ALUB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                // Only entered from DECODE when jumps are built in
                pc_src_s     = PC_SRC_JUMP;
                pc_en_s      = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset forces every strobe low combinationally so an in-flight write is
    // dropped in the same cycle reset is seen, not one cycle later.
    assign pc_en      = pc_en_s      & ~reset;
    assign ir_write   = ir_write_s   & ~reset;
    assign reg_write  = reg_write_s  & ~reset;
    assign mem_read   = mem_read_s   & ~reset;
    assign mem_write  = mem_write_s  & ~reset;
    assign instr_done = instr_done_s & ~reset;
    assign illegal_op = illegal_op_s & ~reset;

    assign pc_src     = pc_src_s;
    assign iord       = iord_s;
    assign reg_dst    = reg_dst_s;
    assign mem_to_reg = mem_to_reg_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign alu_ctrl   = alu_ctrl_s;
    assign state      = reset ? 4'd0 : 4'(state_q);

endmodule
